// File: rtl/parity_frame_controller.sv
// parity_frame_controller: passes parity-protected words one at a time to an
// external parity_checker, counts the errored words in each fixed-length frame,
// reports a status record per frame over valid/ready, and keeps a saturating
// lifetime count of errored words.
module parity_frame_controller #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_parity,
  output logic [WIDTH-1:0] chk_data,
  output logic             chk_parity,
  input  logic             chk_error,
  output logic             st_valid,
  input  logic             st_ready,
  output logic [CNT_W-1:0] st_err_count,
  output logic [CNT_W-1:0] st_first_err_idx,
  output logic             st_frame_ok,
  input  logic             clr_tot,
  output logic [15:0]      tot_err
);

  localparam int unsigned     TOT_W    = 16;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [TOT_W-1:0] TOT_MAX  = '1;

  typedef enum logic [1:0] {
    RECV   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] chk_data_q, chk_data_d;
  logic             chk_parity_q, chk_parity_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic             st_valid_q, st_valid_d;
  logic [TOT_W-1:0] tot_err_q, tot_err_d;
  logic             accept_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RECV;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one CHECK cycle per word, REPORT after the last word of a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RECV:    if (accept_c) state_d = CHECK;
      CHECK:   state_d = (word_idx_q == LAST_IDX) ? REPORT : RECV;
      REPORT:  if (st_ready) state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  // Output logic: words are accepted only in RECV and never while reset is held.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && (state_q == RECV)) begin
      in_ready = 1'b1;
    end
  end

  assign accept_c = in_valid && in_ready;

  // Datapath next-state: capture word, score checker result, manage status and lifetime count.
  always_comb begin
    chk_data_d   = chk_data_q;
    chk_parity_d = chk_parity_q;
    word_idx_d   = word_idx_q;
    err_cnt_d    = err_cnt_q;
    first_idx_d  = first_idx_q;
    st_valid_d   = st_valid_q;
    tot_err_d    = tot_err_q;

    unique case (state_q)
      RECV: begin
        if (accept_c) begin
          chk_data_d   = in_data;
          chk_parity_d = in_parity;
        end
      end
      CHECK: begin
        if (chk_error) begin
          if (err_cnt_q == '0) begin
            first_idx_d = word_idx_q;
          end
          err_cnt_d = err_cnt_q + CNT_W'(1);
          if (tot_err_q != TOT_MAX) begin
            tot_err_d = tot_err_q + TOT_W'(1);
          end
        end
        if (word_idx_q == LAST_IDX) begin
          word_idx_d = '0;
          st_valid_d = 1'b1;
        end else begin
          word_idx_d = word_idx_q + CNT_W'(1);
        end
      end
      REPORT: begin
        if (st_ready) begin
          st_valid_d  = 1'b0;
          err_cnt_d   = '0;
          first_idx_d = '0;
        end
      end
      default: ;
    endcase

    // Clearing the lifetime counter takes priority over a same-cycle increment.
    if (clr_tot) begin
      tot_err_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_data_q   <= '0;
      chk_parity_q <= 1'b0;
      word_idx_q   <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      st_valid_q   <= 1'b0;
      tot_err_q    <= '0;
    end else begin
      chk_data_q   <= chk_data_d;
      chk_parity_q <= chk_parity_d;
      word_idx_q   <= word_idx_d;
      err_cnt_q    <= err_cnt_d;
      first_idx_q  <= first_idx_d;
      st_valid_q   <= st_valid_d;
      tot_err_q    <= tot_err_d;
    end
  end

  assign chk_data         = chk_data_q;
  assign chk_parity       = chk_parity_q;
  assign st_valid         = st_valid_q;
  assign st_err_count     = err_cnt_q;
  assign st_first_err_idx = first_idx_q;
  assign st_frame_ok      = (err_cnt_q == '0);
  assign tot_err          = tot_err_q;

endmodule

// File: tb/tb_parity_frame_controller.sv
// Directed bench for parity_frame_controller with 4-word frames and an
// even-parity checker modelled on chk_data/chk_parity.
module tb_parity_frame_controller;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned CNT_W     = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_parity;
  logic [WIDTH-1:0] chk_data;
  logic             chk_parity;
  logic             chk_error;
  logic             st_valid;
  logic             st_ready;
  logic [CNT_W-1:0] st_err_count;
  logic [CNT_W-1:0] st_first_err_idx;
  logic             st_frame_ok;
  logic             clr_tot;
  logic [15:0]      tot_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Even-parity checker: flags an error when the parity bit disagrees with the data XOR.
  assign chk_error = (chk_parity != (^chk_data));

  parity_frame_controller #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_parity       (in_parity),
    .chk_data        (chk_data),
    .chk_parity      (chk_parity),
    .chk_error       (chk_error),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_err_count    (st_err_count),
    .st_first_err_idx(st_first_err_idx),
    .st_frame_ok     (st_frame_ok),
    .clr_tot         (clr_tot),
    .tot_err         (tot_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a word, waits (bounded) for in_ready, returns in the CHECK cycle.
  task automatic send_word(input logic [7:0] d, input logic p, output int acc);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    tick();
    acc = cyc;
  endtask

  // Called in the CHECK cycle of the last word: status must appear on the next edge.
  task automatic expect_status(input string tag, input int cnt, input int first,
                               input int ok, input int tot);
    check({tag, "_sv_low_in_check"}, 32'(st_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    check({tag, "_st_valid"},   32'(st_valid),         32'd1);
    check({tag, "_err_count"},  32'(st_err_count),     32'(cnt));
    check({tag, "_first_idx"},  32'(st_first_err_idx), 32'(first));
    check({tag, "_frame_ok"},   32'(st_frame_ok),      32'(ok));
    check({tag, "_tot_err"},    32'(tot_err),          32'(tot));
    check({tag, "_in_ready"},   32'(in_ready),         32'd0);
  endtask

  task automatic release_status(input string tag);
    st_ready = 1'b1;
    tick();
    st_ready = 1'b0;
    check({tag, "_rel_st_valid"}, 32'(st_valid), 32'd0);
    check({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int a0, a1, a2, a3;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_parity = 1'b0;
    st_ready  = 1'b0;
    clr_tot   = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_in_ready_during", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_st_valid",  32'(st_valid), 32'd0);
    check("rst_tot_err",   32'(tot_err),  32'd0);
    check("rst_chk_data",  32'(chk_data), 32'h00);

    // Clean frame, back-to-back
    send_word(8'hA5, 1'b0, a0);
    check("clean_chk_data0", 32'(chk_data), 32'hA5);
    send_word(8'h01, 1'b1, a1);
    send_word(8'hFF, 1'b0, a2);
    send_word(8'h07, 1'b1, a3);
    check("clean_gap1", 32'(a1 - a0), 32'd2);
    check("clean_gap2", 32'(a2 - a1), 32'd2);
    check("clean_gap3", 32'(a3 - a2), 32'd2);
    expect_status("clean", 0, 0, 1, 0);
    release_status("clean");

    // Errored frame: words 1 and 3 carry a wrong parity bit
    send_word(8'hA5, 1'b0, a0);
    send_word(8'h01, 1'b0, a0);
    send_word(8'hFF, 1'b0, a0);
    send_word(8'h07, 1'b0, a0);
    expect_status("err", 2, 1, 0, 2);
    release_status("err");

    send_word(8'hA5, 1'b0, a0);
    send_word(8'h01, 1'b1, a0);
    send_word(8'hFF, 1'b0, a0);
    send_word(8'h07, 1'b1, a0);
    expect_status("clean2", 0, 0, 1, 2);
    release_status("clean2");

    // Backpressure: errors at words 0 and 3, status held while st_ready is low
    send_word(8'hA5, 1'b1, a0);
    send_word(8'h01, 1'b1, a0);
    send_word(8'hFF, 1'b0, a0);
    send_word(8'h07, 1'b0, a0);
    expect_status("bp", 2, 0, 0, 4);
    in_valid  = 1'b1;
    in_data   = 8'h33;
    in_parity = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_st_valid",  32'(st_valid),         32'd1);
      check("bp_err_count", 32'(st_err_count),     32'd2);
      check("bp_first_idx", 32'(st_first_err_idx), 32'd0);
      check("bp_frame_ok",  32'(st_frame_ok),      32'd0);
      check("bp_in_ready",  32'(in_ready),         32'd0);
      check("bp_chk_data",  32'(chk_data),         32'h07);
    end
    in_valid = 1'b0;
    release_status("bp");
    check("bp_chk_data_after", 32'(chk_data), 32'h07);

    // clr_tot coincident with an erroring CHECK: clear wins
    send_word(8'h01, 1'b0, a0);
    clr_tot = 1'b1;
    tick();
    clr_tot = 1'b0;
    check("clr_tot_wins", 32'(tot_err), 32'd0);
    send_word(8'hA5, 1'b0, a0);
    send_word(8'hFF, 1'b0, a0);
    send_word(8'h07, 1'b1, a0);
    expect_status("clr", 1, 0, 0, 0);
    release_status("clr");

    // Reset mid-frame discards the partial frame
    send_word(8'h01, 1'b0, a0);
    send_word(8'hA5, 1'b0, a0);
    in_valid = 1'b0;
    tick();
    check("mid_tot_before_rst", 32'(tot_err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_tot_err",  32'(tot_err),  32'd0);
    check("mid_rst_st_valid", 32'(st_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    send_word(8'hA5, 1'b0, a0);
    send_word(8'h01, 1'b1, a0);
    tick();
    check("mid_no_early_status", 32'(st_valid), 32'd0);
    send_word(8'hFF, 1'b0, a0);
    send_word(8'h07, 1'b1, a0);
    expect_status("mid", 0, 0, 1, 0);
    release_status("mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_frame_controller.md
Name: parity_frame_controller

Overview:
- Sequences a stream of parity-protected words through one external `parity_checker` instance (even parity: error when `parity_bit != ^data_in`).
- Groups words into fixed-length frames and counts errors per frame.
- Reports per-frame status over a valid/ready handshake and keeps a saturating lifetime error counter.
- Sits between the word source and the link-status logic.

Parameters:
- WIDTH, 8, data word width; must match the connected parity_checker.
- FRAME_LEN, 16, words per frame; must be >= 2.
- CNT_W, 5, width of the per-frame counters; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source has a word.
- in_ready  out  1  controller accepts a word this cycle.
- in_data  in  WIDTH  data word.
- in_parity  in  1  transmitted even-parity bit.
- chk_data  out  WIDTH  registered word driven to parity_checker.data_in.
- chk_parity  out  1  registered parity driven to parity_checker.parity_bit.
- chk_error  in  1  parity_checker.error_flag, purely combinational from chk_data/chk_parity.
- st_valid  out  1  frame status available.
- st_ready  in  1  status consumer accepts.
- st_err_count  out  CNT_W  errored words in the frame.
- st_first_err_idx  out  CNT_W  index (0-based) of the first errored word; 0 if none.
- st_frame_ok  out  1  1 when st_err_count == 0.
- clr_tot  in  1  clear the lifetime counter.
- tot_err  out  16  lifetime errored-word count, saturating at 16'hFFFF.

Behaviour:

FSM states: RECV, CHECK, REPORT. Reset state is RECV.

Reset values (registered):
- st_valid=0.
- chk_data=0, chk_parity=0.
- word_idx=0, err_cnt=0, first_idx=0.
- tot_err=0.

Outputs:
- in_ready = (state==RECV), combinational from state. It is 0 during the reset cycle and 1 in the first cycle after reset.
- st_err_count, st_first_err_idx and st_frame_ok come directly from the err_cnt/first_idx registers. They are meaningful only while st_valid=1 and are stable throughout REPORT.

RECV:
- On in_valid && in_ready: chk_data<=in_data, chk_parity<=in_parity; go to CHECK.
- Otherwise hold.

CHECK (exactly one cycle; in_ready=0):
- If chk_error: if err_cnt==0 then first_idx<=word_idx; err_cnt<=err_cnt+1; tot_err increments (saturating).
- If word_idx==FRAME_LEN-1: word_idx<=0, st_valid<=1, go to REPORT.
- Else: word_idx<=word_idx+1, go to RECV.

REPORT (in_ready=0; status held stable):
- On st_ready: st_valid<=0, err_cnt<=0, first_idx<=0; go to RECV.
- st_ready while st_valid=0 is ignored.

Throughput and latency:
- Maximum rate is one word per 2 cycles.
- st_valid rises on the clock edge ending the CHECK cycle of the last word: 2 cycles after the last word is accepted.

tot_err:
- Saturates: an increment at 16'hFFFF keeps 16'hFFFF.
- If clr_tot and an increment occur in the same cycle, clear wins (tot_err=0).
- clr_tot is effective in any state.

Boundaries:
- in_valid while not in RECV: word not accepted; the source must hold it.
- in_data/in_parity changes while in CHECK or REPORT have no effect on chk_data.
- rst mid-frame or mid-REPORT: the partial frame and any pending status are discarded; tot_err is cleared; the next accepted word is index 0.
- chk_error is sampled only in CHECK; its value in other states is ignored.

Test Plan:
1. Bench connects a real parity_checker to chk_data/chk_parity/chk_error; FRAME_LEN overridden to 4 for scenarios 2-6.
2. Reset: hold rst 2 cycles then release -> in_ready=1, st_valid=0, tot_err=0, chk_data=8'h00 in the first post-reset cycle.
3. Clean frame: send A5/p0, 01/p1, FF/p0, 07/p1 back-to-back with in_valid held -> one word accepted per 2 cycles; st_valid=1 two cycles after the 4th accept; st_err_count=0, st_frame_ok=1, st_first_err_idx=0, tot_err=0.
4. Errored frame: A5/p0, 01/p0, FF/p0, 07/p0 -> st_err_count=2, st_first_err_idx=1, st_frame_ok=0, tot_err=2. After st_ready, the next clean frame reports count 0 and tot_err stays 2.
5. Backpressure: in REPORT hold st_ready=0 for 5 cycles with in_valid=1 -> st_valid and all status fields stable, in_ready=0, no word consumed. Raise st_ready -> next cycle st_valid=0, in_ready=1.
6. Clear/reset:
   - Assert clr_tot in the same cycle as an erroring CHECK -> tot_err=0.
   - Separately, assert rst after 2 words of a frame -> no status produced; the following 4 clean words yield one status with st_err_count=0.
